// File: rtl/cdc_handshake_ctrl_if.sv
// Word-transfer bus between the source-side producer, the handshake
// controller and the clk_2-domain responder.
interface cdc_handshake_ctrl_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ack_in;
    logic         req_out;
    logic [N-1:0] data_out;

    // Controller side: consumes the offered word and the ack, drives req/data.
    modport master (
        input  in_data,
        input  in_valid,
        input  ack_in,
        output in_ready,
        output req_out,
        output data_out
    );

    // Producer/responder side: the mirror image of the controller.
    modport slave (
        output in_data,
        output in_valid,
        output ack_in,
        input  in_ready,
        input  req_out,
        input  data_out
    );
endinterface

// File: rtl/cdc_handshake_ctrl.sv
// Source-domain controller that moves one word at a time into the clk_2
// domain with a 4-phase req/ack handshake, with per-phase timeout and a
// completed-transfer counter.
module cdc_handshake_ctrl #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned TIMEOUT     = 200,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   err_clr,
    cdc_handshake_ctrl_if.master   bus,
    output logic                   done,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       xfer_cnt,
    output logic [2:0]             state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_REQ   = 3'd2,
        S_REL   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam bit            TO_EN     = (TIMEOUT != 0);
    localparam int unsigned   TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic                   r_req;
    logic [N-1:0]           r_data;
    logic                   r_done;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [TO_W-1:0]        r_timer;

    state_t                 w_state_nx;
    logic                   w_req_nx;
    logic [N-1:0]           w_data_nx;
    logic                   w_done_nx;
    logic                   w_err_nx;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic [TO_W-1:0]        w_timer_nx;
    logic                   w_ack_s;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_to_hit;
    logic [TO_W-1:0]        w_timer_inc;

    assign w_ack_s     = r_sync[SYNC_STAGES-1];
    assign w_in_ready  = !rst && ena && (r_state == S_IDLE) && !w_ack_s;
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_to_hit    = TO_EN && (r_timer == TO_LAST);
    assign w_timer_inc = (r_timer == TO_MAX) ? r_timer : r_timer + TO_W'(1);

    // Ack synchronizer; free-running so the ack level is current when ena returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_in};
        end
    end

    // Handshake state and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
            r_timer <= w_timer_nx;
        end
    end

    // Next-state logic; a phase exit beats a timeout in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_data_nx  = r_data;
        w_done_nx  = 1'b0;
        w_err_nx   = r_err;
        w_cnt_nx   = r_cnt;
        w_timer_nx = r_timer;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_data_nx  = bus.in_data;
                        w_state_nx = S_SETUP;
                    end
                end
                S_SETUP: begin
                    w_req_nx   = 1'b1;
                    w_timer_nx = '0;
                    w_state_nx = S_REQ;
                end
                S_REQ: begin
                    if (w_ack_s) begin
                        w_req_nx   = 1'b0;
                        w_timer_nx = '0;
                        w_state_nx = S_REL;
                    end else if (w_to_hit) begin
                        w_req_nx   = 1'b0;
                        w_err_nx   = 1'b1;
                        w_state_nx = S_ERR;
                    end else begin
                        w_timer_nx = w_timer_inc;
                    end
                end
                S_REL: begin
                    if (!w_ack_s) begin
                        w_done_nx  = 1'b1;
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                        w_state_nx = S_IDLE;
                    end else if (w_to_hit) begin
                        w_req_nx   = 1'b0;
                        w_err_nx   = 1'b1;
                        w_state_nx = S_ERR;
                    end else begin
                        w_timer_nx = w_timer_inc;
                    end
                end
                S_ERR: begin
                    if (err_clr && !w_ack_s) begin
                        w_err_nx   = 1'b0;
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.req_out  = r_req;
    assign bus.data_out = r_data;
    assign done         = r_done && ena;
    assign timeout_err  = r_err;
    assign xfer_cnt     = r_cnt;
    assign state_out    = r_state;

endmodule

// File: tb/tb_cdc_handshake_ctrl.sv
// Directed bench for cdc_handshake_ctrl: scoreboard of offered words checked
// against data_out when req_out rises, plus a counter/state model.
module tb_cdc_handshake_ctrl;

    localparam int unsigned N     = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TO_W  = 8;
    localparam int unsigned TMO   = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             err_clr;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] xfer_cnt;
    logic [2:0]       state_out;

    cdc_handshake_ctrl_if #(.N(N)) bus ();

    cdc_handshake_ctrl #(
        .N(N), .SYNC_STAGES(SYNC), .TO_W(TO_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .err_clr(err_clr),
        .bus(bus),
        .done(done),
        .timeout_err(timeout_err),
        .xfer_cnt(xfer_cnt),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    int               n_chk  = 0;
    int               n_fail = 0;
    logic [N-1:0]     exp_q[$];
    logic [CNT_W-1:0] m_cnt  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll req_out for a level with a bounded cycle budget; n = cycles waited.
    task automatic wait_req(input logic v, output int n);
        n = 0;
        while (bus.req_out !== v && n < 60) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(bus.req_out), 32'(v));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("done_pulse", 32'(done), 32'd1);
    endtask

    task automatic pop_check(output logic [N-1:0] e);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("data_at_req", 32'(bus.data_out), 32'(e));
    endtask

    task automatic offer(input logic [N-1:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        exp_q.push_back(w);
        chk("in_ready_offer", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("state_setup", 32'(state_out), 32'd1);
    endtask

    // Full responder-driven transfer: ack 3 clk after req rises/falls.
    task automatic xfer(input logic [N-1:0] nxt, input bit more, output int nreq);
        int n;
        logic [N-1:0] e;
        wait_req(1'b1, nreq);
        pop_check(e);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (more) begin
            bus.in_data = nxt;
            exp_q.push_back(nxt);
        end else begin
            bus.in_valid = 1'b0;
        end
        repeat (3) tick();
        bus.ack_in = 1'b1;
        wait_req(1'b0, n);
        chk("data_held_rel", 32'(bus.data_out), 32'(e));
        repeat (3) tick();
        bus.ack_in = 1'b0;
        wait_done();
        m_cnt = m_cnt + CNT_W'(1);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        chk("state_idle", 32'(state_out), 32'd0);
        chk("data_held_done", 32'(bus.data_out), 32'(e));
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, 32'(state_out), 32'd0);
        chk({tag, "_req"}, 32'(bus.req_out), 32'd0);
        chk({tag, "_data"}, 32'(bus.data_out), 32'd0);
        chk({tag, "_cnt"}, 32'(xfer_cnt), 32'd0);
        chk({tag, "_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        int n;
        logic [N-1:0] e;
        rst          = 1'b1;
        ena          = 1'b1;
        err_clr      = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.ack_in   = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(bus.in_ready), 32'd1);

        // Single transfer with latency checks.
        offer(8'hA5);
        chk("t1_data_after_accept", 32'(bus.data_out), 32'hA5);
        chk("t1_req_low_setup", 32'(bus.req_out), 32'd0);
        xfer('0, 1'b0, n);
        chk("t1_req_latency", 32'(n), 32'd1);

        // Back-to-back with in_valid held high.
        bus.in_data  = 8'h01;
        bus.in_valid = 1'b1;
        exp_q.push_back(8'h01);
        xfer(8'h02, 1'b1, n);
        xfer(8'h03, 1'b1, n);
        xfer('0, 1'b0, n);
        offer(8'h04);
        xfer('0, 1'b0, n);
        tick();
        chk("b2b_no_extra", 32'(state_out), 32'd0);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout with no ack.
        offer(8'h3C);
        wait_req(1'b1, n);
        pop_check(e);
        wait_req(1'b0, n);
        chk("to_cycles", 32'(n), 32'(TMO));
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_state", 32'(state_out), 32'd4);
        chk("to_cnt", 32'(xfer_cnt), 32'(m_cnt));
        chk("to_rdy", 32'(bus.in_ready), 32'd0);
        chk("to_data", 32'(bus.data_out), 32'h3C);

        // err_clr ignored while ack is high, honoured once it drops.
        bus.ack_in = 1'b1;
        repeat (3) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_hold_state", 32'(state_out), 32'd4);
        chk("err_hold_flag", 32'(timeout_err), 32'd1);
        bus.ack_in = 1'b0;
        repeat (SYNC + 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_flag", 32'(timeout_err), 32'd0);
        chk("err_clr_state", 32'(state_out), 32'd0);
        chk("err_clr_rdy", 32'(bus.in_ready), 32'd1);

        // ena low freezes the timer mid-REQ.
        offer(8'h5A);
        wait_req(1'b1, n);
        pop_check(e);
        repeat (3) tick();
        ena = 1'b0;
        repeat (20) tick();
        chk("ena_state", 32'(state_out), 32'd2);
        chk("ena_req", 32'(bus.req_out), 32'd1);
        chk("ena_err", 32'(timeout_err), 32'd0);
        chk("ena_rdy", 32'(bus.in_ready), 32'd0);
        ena = 1'b1;
        wait_req(1'b0, n);
        chk("ena_to_rest", 32'(n), 32'(TMO - 3));
        chk("ena_to_state", 32'(state_out), 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ena_clr_state", 32'(state_out), 32'd0);

        // Asynchronous reset in REL.
        offer(8'h77);
        wait_req(1'b1, n);
        pop_check(e);
        repeat (3) tick();
        bus.ack_in = 1'b1;
        wait_req(1'b0, n);
        tick();
        chk("rel_state", 32'(state_out), 32'd3);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        bus.ack_in = 1'b0;
        m_cnt      = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Counter restarts from zero after reset.
        offer(8'h99);
        xfer('0, 1'b0, n);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
